// File: rtl/seg_scan_pkg.sv
// Shared constants for the scanned 7-segment bus decoder: active-low segment
// patterns, special nibble codes and the slot map of the display frame.
package seg_scan_pkg;

  // Active-low segment patterns, bit6=g ... bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] NIB_BLANK   = 4'hF;
  localparam logic [3:0] NIB_ILLEGAL = 4'hE;

  // Slot map: mm:ss in slots 3..0, volume in 5..4, track in 7..6
  localparam int SLOT_SEC0 = 0;
  localparam int SLOT_SEC1 = 1;
  localparam int SLOT_MIN0 = 2;
  localparam int SLOT_MIN1 = 3;
  localparam int SLOT_VOL0 = 4;
  localparam int SLOT_VOL1 = 5;
  localparam int SLOT_TRK0 = 6;
  localparam int SLOT_TRK1 = 7;

  function automatic logic nib_is_digit(logic [3:0] nib);
    return nib <= 4'd9;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low 7-segment pattern into a nibble:
// 0-9 for digits, blank for all segments off, illegal for anything else.
module seg7_to_bcd
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nib
);

  // Pattern lookup; unknown patterns collapse to the illegal code
  always_comb begin
    nib = NIB_ILLEGAL;
    case (seg)
      SEG_0:     nib = 4'd0;
      SEG_1:     nib = 4'd1;
      SEG_2:     nib = 4'd2;
      SEG_3:     nib = 4'd3;
      SEG_4:     nib = 4'd4;
      SEG_5:     nib = 4'd5;
      SEG_6:     nib = 4'd6;
      SEG_7:     nib = 4'd7;
      SEG_8:     nib = 4'd8;
      SEG_9:     nib = 4'd9;
      SEG_BLANK: nib = NIB_BLANK;
      default:   nib = NIB_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the eight digits shown on a multiplexed 7-segment display by
// watching its scan bus, then publishes playback time, volume and track.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [6:0]  SEG,
  input  logic [7:0]  SHIFT,
  input  logic        DOT,
  output logic [31:0] DIGITS,
  output logic [7:0]  DOT_POS,
  output logic [15:0] TIME_SEC,
  output logic [4:0]  VOL_LEVEL,
  output logic [3:0]  TRACK,
  output logic        FRAME_VALID,
  output logic        FRAME_ERR,
  output logic        SHIFT_ERR,
  output logic        LOCKED
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  function automatic logic [15:0] to_seconds(logic [3:0] m1, logic [3:0] m0,
                                             logic [3:0] s1, logic [3:0] s0);
    return 16'(m1) * 16'd600 + 16'(m0) * 16'd60 + 16'(s1) * 16'd10 + 16'(s0);
  endfunction

  function automatic logic [6:0] two_digit(logic [3:0] hi, logic [3:0] lo);
    return 7'(hi) * 7'd10 + 7'(lo);
  endfunction

  logic [6:0]      seg_p0, seg_p1;
  logic [7:0]      shift_p0, shift_p1;
  logic            dot_p0, dot_p1;
  logic [15:0]     bus_prev;
  logic [15:0]     bus_now;
  logic            change;
  logic [CW-1:0]   settle_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            sample;
  logic [3:0]      zeros;
  logic [2:0]      slot;
  logic            slot_sample;
  logic            shift_bad;
  logic            timeout_hit;
  logic            publish;
  logic            all_digit;
  logic [3:0]      dec_nib;
  logic [7:0][3:0] shadow_nib;
  logic [7:0]      shadow_dot;
  logic [7:0]      seen;
  logic [6:0]      vol_full;
  logic [6:0]      trk_full;

  // Stage p0/p1: two-flop synchronizers, reset to an idle (all-off) bus
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_p0   <= SEG_BLANK;
      seg_p1   <= SEG_BLANK;
      shift_p0 <= 8'hFF;
      shift_p1 <= 8'hFF;
      dot_p0   <= 1'b1;
      dot_p1   <= 1'b1;
    end else begin
      seg_p0   <= SEG;
      seg_p1   <= seg_p0;
      shift_p0 <= SHIFT;
      shift_p1 <= shift_p0;
      dot_p0   <= DOT;
      dot_p1   <= dot_p0;
    end
  end

  assign bus_now = {seg_p1, shift_p1, dot_p1};
  assign change  = (bus_now != bus_prev);
  // The counter saturates at SETTLE so SETTLE-1 is hit exactly once per dwell
  assign sample  = !change && (settle_cnt == CW'(SETTLE - 1));

  // Settle counter: restarts on any bus change, otherwise counts up and sticks
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus_prev   <= 16'hFFFF;
      settle_cnt <= '0;
    end else begin
      bus_prev <= bus_now;
      if (change)
        settle_cnt <= '0;
      else if (settle_cnt != CW'(SETTLE))
        settle_cnt <= settle_cnt + CW'(1);
    end
  end

  // Count active-low enables and remember which slot is selected
  always_comb begin
    zeros = 4'd0;
    slot  = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (!shift_p1[k]) begin
        zeros = zeros + 4'd1;
        slot  = 3'(k);
      end
    end
  end

  assign slot_sample = sample && (zeros == 4'd1);
  assign shift_bad   = sample && (zeros != 4'd1);
  assign timeout_hit = !sample && (idle_cnt == IW'(TIMEOUT - 1));
  assign publish     = (seen == 8'hFF);

  seg7_to_bcd u_dec (
    .seg (seg_p1),
    .nib (dec_nib)
  );

  // A frame is only clean when every slot holds a decimal digit
  always_comb begin
    all_digit = 1'b1;
    for (int k = 0; k < 8; k++)
      if (!nib_is_digit(shadow_nib[k])) all_digit = 1'b0;
  end

  assign vol_full = two_digit(shadow_nib[SLOT_VOL1], shadow_nib[SLOT_VOL0]);
  assign trk_full = two_digit(shadow_nib[SLOT_TRK1], shadow_nib[SLOT_TRK0]);

  // Idle counter: time since the last sample, saturating at TIMEOUT
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      idle_cnt <= '0;
    else if (sample)
      idle_cnt <= '0;
    else if (idle_cnt != IW'(TIMEOUT))
      idle_cnt <= idle_cnt + IW'(1);
  end

  // Shadow capture and seen mask; a sample coinciding with publish starts the next frame
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_nib <= {8{NIB_BLANK}};
      shadow_dot <= '0;
      seen       <= '0;
    end else begin
      if (slot_sample) begin
        shadow_nib[slot] <= dec_nib;
        shadow_dot[slot] <= ~dot_p1;
      end
      if (publish || timeout_hit)
        seen <= slot_sample ? (8'h01 << slot) : 8'h00;
      else if (slot_sample)
        seen[slot] <= 1'b1;
    end
  end

  // Stage p2: publish the frame, update decoded values and lock state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DIGITS      <= 32'hFFFF_FFFF;
      DOT_POS     <= '0;
      TIME_SEC    <= '0;
      VOL_LEVEL   <= '0;
      TRACK       <= '0;
      FRAME_VALID <= 1'b0;
      FRAME_ERR   <= 1'b0;
      SHIFT_ERR   <= 1'b0;
      LOCKED      <= 1'b0;
    end else begin
      FRAME_VALID <= publish;
      FRAME_ERR   <= publish && !all_digit;
      SHIFT_ERR   <= shift_bad;
      if (publish) begin
        DIGITS  <= shadow_nib;
        DOT_POS <= shadow_dot;
        if (all_digit) begin
          TIME_SEC  <= to_seconds(shadow_nib[SLOT_MIN1], shadow_nib[SLOT_MIN0],
                                  shadow_nib[SLOT_SEC1], shadow_nib[SLOT_SEC0]);
          VOL_LEVEL <= vol_full[4:0];
          TRACK     <= trk_full[3:0];
          LOCKED    <= 1'b1;
        end
      end else if (timeout_hit) begin
        LOCKED <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: stimulus pushes expected frames into a
// queue, a monitor pops and compares whenever FRAME_VALID is presented.
module tb_seg_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 300;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [6:0]  SEG = 7'h7F;
  logic [7:0]  SHIFT = 8'hFF;
  logic        DOT = 1'b1;
  logic [31:0] DIGITS;
  logic [7:0]  DOT_POS;
  logic [15:0] TIME_SEC;
  logic [4:0]  VOL_LEVEL;
  logic [3:0]  TRACK;
  logic        FRAME_VALID, FRAME_ERR, SHIFT_ERR, LOCKED;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .SEG(SEG), .SHIFT(SHIFT), .DOT(DOT),
    .DIGITS(DIGITS), .DOT_POS(DOT_POS), .TIME_SEC(TIME_SEC),
    .VOL_LEVEL(VOL_LEVEL), .TRACK(TRACK), .FRAME_VALID(FRAME_VALID),
    .FRAME_ERR(FRAME_ERR), .SHIFT_ERR(SHIFT_ERR), .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] digits;
    logic [7:0]  dots;
    logic [15:0] tsec;
    logic [4:0]  vol;
    logic [3:0]  trk;
    logic        err;
    logic        locked;
  } frame_t;

  frame_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nframes = 0;
  int nshift_err = 0;
  int last_frame_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Hand-written active-low patterns; 14 is the letter A (illegal), 15 blank
  function automatic logic [6:0] pat(int n);
    case (n)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      14: return 7'b0001000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic put(logic [7:0] sh, logic [6:0] sg, logic dt, int dwell);
    @(negedge CLK);
    SHIFT = sh;
    SEG   = sg;
    DOT   = dt;
    repeat (dwell - 1) @(negedge CLK);
  endtask

  task automatic slot(int k, logic [31:0] digs, logic [7:0] dots, int dwell);
    logic [7:0] sel;
    sel = 8'(8'h01 << k);
    put(~sel, pat(int'(digs[4*k +: 4])), ~dots[k], dwell);
  endtask

  task automatic slots(logic [31:0] digs, logic [7:0] dots, int lo, int hi, int dwell);
    for (int k = lo; k <= hi; k++) slot(k, digs, dots, dwell);
  endtask

  task automatic expect_frame(logic [31:0] d, logic [7:0] dp, logic [15:0] ts,
                              logic [4:0] v, logic [3:0] t, logic e);
    frame_t f;
    f.digits = d; f.dots = dp; f.tsec = ts; f.vol = v; f.trk = t;
    f.err = e; f.locked = 1'b1;
    exp_q.push_back(f);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_digits"}, DIGITS, 32'hFFFF_FFFF);
    check({tag, "_dotpos"}, 32'(DOT_POS), 32'h0);
    check({tag, "_time"}, 32'(TIME_SEC), 32'h0);
    check({tag, "_vol"}, 32'(VOL_LEVEL), 32'h0);
    check({tag, "_track"}, 32'(TRACK), 32'h0);
    check({tag, "_fvalid"}, 32'(FRAME_VALID), 32'h0);
    check({tag, "_ferr"}, 32'(FRAME_ERR), 32'h0);
    check({tag, "_serr"}, 32'(SHIFT_ERR), 32'h0);
    check({tag, "_locked"}, 32'(LOCKED), 32'h0);
  endtask

  // Monitor: compare each published frame against the scoreboard head
  always @(posedge CLK) begin
    #1;
    if (RST_N) begin
      if (SHIFT_ERR) nshift_err++;
      if (FRAME_VALID) begin
        nframes++;
        last_frame_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame actual=%0h required=none", DIGITS);
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          check("frame_digits", DIGITS, e.digits);
          check("frame_dotpos", 32'(DOT_POS), 32'(e.dots));
          check("frame_time", 32'(TIME_SEC), 32'(e.tsec));
          check("frame_vol", 32'(VOL_LEVEL), 32'(e.vol));
          check("frame_track", 32'(TRACK), 32'(e.trk));
          check("frame_err", 32'(FRAME_ERR), 32'(e.err));
          check("frame_locked", 32'(LOCKED), 32'(e.locked));
        end
      end
    end
  end

  initial begin
    int se0;
    int got;

    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset("rst0");
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);

    // 02:35, volume 16, track 3, dot after minutes
    expect_frame(32'h0316_0235, 8'h04, 16'd155, 5'd16, 4'd3, 1'b0);
    slots(32'h0316_0235, 8'h04, 0, 7, 20);
    check("frames_after_1", 32'(nframes), 32'd1);
    check("locked_after_1", 32'(LOCKED), 32'd1);

    // Illegal pattern in slot 4: values hold, error pulses
    expect_frame(32'h050E_0100, 8'h00, 16'd155, 5'd16, 4'd3, 1'b1);
    slots(32'h050E_0100, 8'h00, 0, 7, 20);
    check("frames_after_2", 32'(nframes), 32'd2);

    // Two enables low mid-frame: one SHIFT_ERR, slots 3/4 not marked seen
    expect_frame(32'h1207_1005, 8'h01, 16'd605, 5'd7, 4'd12, 1'b0);
    se0 = nshift_err;
    slots(32'h1207_1005, 8'h01, 0, 2, 20);
    slots(32'h1207_1005, 8'h01, 5, 7, 20);
    put(8'b11100111, pat(8), 1'b1, 10);
    repeat (10) @(negedge CLK);
    check("shift_err_pulses", 32'(nshift_err - se0), 32'd1);
    check("no_frame_after_bad_shift", 32'(nframes), 32'd2);
    slots(32'h1207_1005, 8'h01, 3, 4, 20);
    check("frames_after_3", 32'(nframes), 32'd3);

    // Short dwell on slot 2 is ignored; maxima 99:99, volume 99 -> 3, track 15
    expect_frame(32'h1599_9999, 8'h00, 16'd6039, 5'd3, 4'd15, 1'b0);
    slots(32'h1599_9999, 8'h00, 0, 1, 20);
    slot(2, 32'h1599_9999, 8'h00, 3);
    slots(32'h1599_9999, 8'h00, 3, 7, 20);
    check("no_frame_short_dwell", 32'(nframes), 32'd3);
    slot(2, 32'h1599_9999, 8'h00, 20);
    check("frames_after_4", 32'(nframes), 32'd4);

    // Frozen bus: LOCKED drops TIMEOUT cycles after the last sample,
    // which is TIMEOUT-1 cycles after the FRAME_VALID pulse
    got = -1;
    for (int i = 0; i < TIMEOUT + 50; i++) begin
      @(posedge CLK);
      #1;
      if (!LOCKED) begin
        got = cyc;
        break;
      end
    end
    check("lock_drop_delay", 32'(got - last_frame_cyc), 32'(TIMEOUT - 1));
    check("digits_retained", DIGITS, 32'h1599_9999);
    check("time_retained", 32'(TIME_SEC), 32'd6039);

    // Reset after five slots sampled
    slots(32'h0105_0000, 8'h00, 0, 4, 20);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_reset("rst_mid");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    slots(32'h0105_0000, 8'h00, 5, 7, 20);
    check("no_frame_after_reset", 32'(nframes), 32'd4);
    expect_frame(32'h0105_0000, 8'h00, 16'd0, 5'd5, 4'd1, 1'b0);
    slots(32'h0105_0000, 8'h00, 0, 4, 20);
    check("frames_after_5", 32'(nframes), 32'd5);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    repeat (5) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run length
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
